axil_sram_slave: RTL and testbench

- AXI4-Lite responder that models the instruction/data SRAM answering the core's fetch and load/store requests.
- Replaces the zero-latency combinational memory with a handshaked, multi-cycle slave.
- One outstanding transaction at a time; a single FSM serialises the read and write channels.
- Sits on the core's memory bus; the IFU and LSU arbiter is the upstream master.

---
 rtl/axil_pkg.sv | 16 +
 rtl/axil_sram_slave_if.sv | 33 +++
 rtl/sram_byteen.sv | 29 ++
 rtl/axil_sram_slave.sv | 171 +++++++++++++++++
 tb/tb_axil_sram_slave.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared response codes, FSM states and default address map for the AXI4-Lite SRAM slave.
package axil_pkg;

   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_SLVERR  = 2'b10;
   localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_RESP,
      WR_WAIT,
      WR_RESP
   } axil_state_e;

endpackage

// File: rtl/axil_sram_slave_if.sv
// AXI4-Lite read/write channel bundle; the master drives requests and the slave drives readies and responses.
interface axil_sram_slave_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0]   araddr;
   logic               arvalid;
   logic               arready;
   logic [WIDTH-1:0]   rdata;
   logic [1:0]         rresp;
   logic               rvalid;
   logic               rready;
   logic [WIDTH-1:0]   awaddr;
   logic               awvalid;
   logic               awready;
   logic [WIDTH-1:0]   wdata;
   logic [WIDTH/8-1:0] wstrb;
   logic               wvalid;
   logic               wready;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/sram_byteen.sv
// Word-wide SRAM: synchronous byte-enabled write port, combinational read of the addressed word.
// Contents are never reset.
module sram_byteen #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [WIDTH/8-1:0]    wstrb,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WIDTH/8; i++) begin
            if (wstrb[i]) begin
               mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite SRAM responder, one transaction at a time; response valid LATENCY cycles after accept, held until rready/bready.
// AXIL_SRAM_RAND_DELAY_EN adds an LFSR that stretches latency by 0-3 cycles and randomly withholds IDLE readies.
module axil_sram_slave
   import axil_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               DEPTH_LOG2 = 16,
   parameter logic [WIDTH-1:0] BASE       = WIDTH'(DEFAULT_BASE),
   parameter int               LATENCY    = 2
) (
   input logic              clk,
   input logic              rst,
   axil_sram_slave_if.slave bus
);

   localparam int NSTRB = WIDTH / 8;
`ifdef AXIL_SRAM_RAND_DELAY_EN
   localparam int CW = $clog2(LATENCY + 4);
`else
   localparam int CW = $clog2(LATENCY + 1);
`endif
   localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

   axil_state_e         state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]       cnt_load;
   logic [WIDTH-1:0]    addr_q;
   logic [WIDTH-1:0]    wdata_q;
   logic [NSTRB-1:0]    wstrb_q;
   logic [WIDTH-1:0]    rdata_q;
   logic [1:0]          rresp_q;
   logic [1:0]          bresp_q;

   logic                gate;
   logic                idle_ok;
   logic                rd_fire;
   logic                wr_fire;
   logic                mem_we;
   logic [WIDTH-1:0]    woff;
   logic                in_range;
   logic [DEPTH_LOG2-1:0] widx;
   logic [WIDTH-1:0]    mem_rdata;

`ifdef AXIL_SRAM_RAND_DELAY_EN
   logic [7:0] lfsr_q;
   logic       lfsr_fb;

   // Fibonacci taps 8,6,5,4
   assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 8'h5A;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_fb};
      end
   end

   assign gate     = lfsr_q[2];
   assign cnt_load = LAT_M1 + CW'(lfsr_q[1:0]);
`else
   assign gate     = 1'b1;
   assign cnt_load = LAT_M1;
`endif

   // Readies are forced low while rst is held so every output reads 0 in reset.
   assign idle_ok = (state_q == IDLE) && !rst && gate;
   assign rd_fire = idle_ok && bus.arvalid;
   assign wr_fire = idle_ok && bus.awvalid && bus.wvalid && !bus.arvalid;

   assign bus.arready = idle_ok;
   assign bus.awready = wr_fire;
   assign bus.wready  = wr_fire;
   assign bus.rvalid  = (state_q == RD_RESP);
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign bus.bvalid  = (state_q == WR_RESP);
   assign bus.bresp   = bresp_q;

   // Word offset from BASE; modulo subtraction makes below-BASE addresses land far out of range.
   assign woff     = (addr_q - BASE) >> 2;
   assign in_range = (woff[WIDTH-1:DEPTH_LOG2] == '0);
   assign widx     = woff[DEPTH_LOG2-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_fire) begin
               state_d = RD_WAIT;
               cnt_d   = cnt_load;
            end else if (wr_fire) begin
               state_d = WR_WAIT;
               cnt_d   = cnt_load;
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = RD_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RD_RESP: begin
            if (bus.rready) begin
               state_d = IDLE;
            end
         end
         WR_WAIT: begin
            if (cnt_q == '0) begin
               state_d = WR_RESP;
               mem_we  = in_range && !rst;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WR_RESP: begin
            if (bus.bready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         bresp_q <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == RD_WAIT && cnt_q == '0) begin
            rdata_q <= in_range ? mem_rdata : '0;
            rresp_q <= in_range ? RESP_OKAY : RESP_SLVERR;
         end
         if (state_q == WR_WAIT && cnt_q == '0) begin
            bresp_q <= in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Request latches only move on acceptance, so they need no reset.
   always_ff @(posedge clk) begin
      if (rd_fire) begin
         addr_q <= bus.araddr;
      end else if (wr_fire) begin
         addr_q  <= bus.awaddr;
         wdata_q <= bus.wdata;
         wstrb_q <= bus.wstrb;
      end
   end

   sram_byteen #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_sram (
      .clk   (clk),
      .we    (mem_we),
      .addr  (widx),
      .wdata (wdata_q),
      .wstrb (wstrb_q),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave: scoreboard of expected responses, immediate-assert checks.
module tb_axil_sram_slave;

   localparam int          LAT   = 2;
   localparam logic [31:0] TBASE = 32'h8000_0000;
   localparam logic [31:0] TSPAN = 32'h0004_0000;

   typedef struct {
      logic        is_rd;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   exp_t exp_q[$];
   logic [31:0] model [int];

   always #5 clk = ~clk;

   axil_sram_slave_if #(.WIDTH(32)) bus ();

   axil_sram_slave #(
      .WIDTH      (32),
      .DEPTH_LOG2 (16),
      .BASE       (TBASE),
      .LATENCY    (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >= TBASE) && (a < TBASE + TSPAN);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - TBASE) >> 2);
   endfunction

   task automatic push_rd(input logic [31:0] a);
      exp_t e;
      e.is_rd = 1'b1;
      if (!in_rng(a)) begin
         e.data = 32'h0;
         e.resp = 2'b10;
      end else begin
         e.data = model.exists(widx(a)) ? model[widx(a)] : 32'hx;
         e.resp = 2'b00;
      end
      exp_q.push_back(e);
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_t e;
      logic [31:0] w;
      e.is_rd = 1'b0;
      e.data  = 32'h0;
      e.resp  = in_rng(a) ? 2'b00 : 2'b10;
      if (in_rng(a)) begin
         w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
         for (int i = 0; i < 4; i++) begin
            if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
         end
         model[widx(a)] = w;
      end
      exp_q.push_back(e);
   endtask

   task automatic sb_check_r(input string tag);
      exp_t e;
      check({tag, "_sb_pending"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_kind"}, 32'(e.is_rd), 32'd1);
         check({tag, "_rdata"}, bus.rdata, e.data);
         check({tag, "_rresp"}, 32'(bus.rresp), 32'(e.resp));
      end
   endtask

   task automatic sb_check_b(input string tag);
      exp_t e;
      check({tag, "_sb_pending"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_kind"}, 32'(e.is_rd), 32'd0);
         check({tag, "_bresp"}, 32'(bus.bresp), 32'(e.resp));
      end
   endtask

   task automatic wait_rvalid(output int n);
      n = 0;
      while (bus.rvalid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_bvalid(output int n);
      n = 0;
      while (bus.bvalid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
   endtask

   // Full read: accept, latency, data, optional rready stall, return to IDLE.
   task automatic do_read(input string tag, input logic [31:0] a, input int hold);
      int n;
      logic [31:0] d0;
      push_rd(a);
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      #1;
      n = 0;
      while (bus.arready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_arready"}, 32'(bus.arready), 32'd1);
      tick();
      bus.arvalid = 1'b0;
      wait_rvalid(n);
      check({tag, "_latency"}, 32'(n), 32'(LAT));
      sb_check_r(tag);
      d0 = bus.rdata;
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_rvalid"}, 32'(bus.rvalid), 32'd1);
         check({tag, "_hold_rdata"}, bus.rdata, d0);
         check({tag, "_hold_arready"}, 32'(bus.arready), 32'd0);
      end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      #1;
      check({tag, "_rvalid_drop"}, 32'(bus.rvalid), 32'd0);
      check({tag, "_idle"}, 32'(bus.arready), 32'd1);
   endtask

   task automatic finish_write(input string tag);
      int n;
      wait_bvalid(n);
      check({tag, "_latency"}, 32'(n), 32'(LAT));
      sb_check_b(tag);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      #1;
      check({tag, "_bvalid_drop"}, 32'(bus.bvalid), 32'd0);
      check({tag, "_idle"}, 32'(bus.arready), 32'd1);
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      int n;
      push_wr(a, d, s);
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      #1;
      n = 0;
      while (bus.awready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_awready"}, 32'(bus.awready), 32'd1);
      check({tag, "_wready"}, 32'(bus.wready), 32'd1);
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      finish_write(tag);
   endtask

   initial begin
      int n;
      rst         = 1'b1;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_arready", 32'(bus.arready), 32'd0);
      check("rst_awready", 32'(bus.awready), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_rresp", 32'(bus.rresp), 32'd0);
      check("rst_bresp", 32'(bus.bresp), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_arready", 32'(bus.arready), 32'd1);
      tick();

      // Lone AW or W must not be accepted
      bus.awvalid = 1'b1;
      #1;
      check("lone_aw", 32'(bus.awready), 32'd0);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b1;
      #1;
      check("lone_w", 32'(bus.wready), 32'd0);
      bus.wvalid = 1'b0;
      tick();

      // Preload and read latency
      do_write("preload", TBASE, 32'hDEAD_BEEF, 4'hF);
      do_read("rd_lat", TBASE, 0);
      do_read("rd_lowbits", TBASE + 32'd3, 0);

      // Byte-enable write over all-ones
      do_write("fill", TBASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
      do_write("strb", TBASE + 32'h10, 32'h1122_3344, 4'b0101);
      do_read("strb_rb", TBASE + 32'h10, 0);
      check("strb_value", bus.rdata, 32'hFF22_FF44);

      // Response backpressure
      do_read("bp", TBASE + 32'h10, 5);

      // Simultaneous AR/AW/W: read first, write after
      push_rd(TBASE + 32'h10);
      bus.araddr  = TBASE + 32'h10;
      bus.awaddr  = TBASE + 32'h20;
      bus.wdata   = 32'hA5A5_0F0F;
      bus.wstrb   = 4'hF;
      bus.arvalid = 1'b1;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      #1;
      check("sim_arready", 32'(bus.arready), 32'd1);
      check("sim_awready", 32'(bus.awready), 32'd0);
      check("sim_wready", 32'(bus.wready), 32'd0);
      tick();
      bus.arvalid = 1'b0;
      check("sim_awready_busy", 32'(bus.awready), 32'd0);
      wait_rvalid(n);
      check("sim_rd_latency", 32'(n), 32'(LAT));
      sb_check_r("sim_rd");
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      #1;
      check("sim_awready_after", 32'(bus.awready), 32'd1);
      push_wr(TBASE + 32'h20, 32'hA5A5_0F0F, 4'hF);
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      finish_write("sim_wr");
      do_read("sim_rb", TBASE + 32'h20, 0);

      // Out-of-range accesses
      do_read("oor_rd", 32'h7FFF_FFFC, 0);
      do_write("oor_wr", 32'h8004_0000, 32'h1234_5678, 4'hF);
      do_read("oor_alias", TBASE, 0);

      // Reset while in RD_WAIT
      bus.araddr  = TBASE;
      bus.arvalid = 1'b1;
      #1;
      tick();
      bus.arvalid = 1'b0;
      check("rdwait_busy", 32'(bus.arready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rdwait_rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rdwait_rst_arready", 32'(bus.arready), 32'd1);
      do_read("after_rst", TBASE + 32'h10, 0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
